pcm_frame_packer: RTL and testbench

//   Sits downstream of the per-mic CIC decimators and feeds the SPI slave.
//   - Captures one PCM frame (one sample per mic) on each in_valid strobe.
//   - Buffers whole frames in a circular frame store.
//   - Serves each frame to the host as 24-bit words: a header word, then NUM_MICS

---
 rtl/pcm_frame_packer.sv | 115 +++++++++++
 tb/tb_pcm_frame_packer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pcm_frame_packer.sv
// pcm_frame_packer: buffers whole PCM frames and serves them to an SPI slave as header + sample words.
// Optional: define PACKER_CHECKSUM_EN to append a per-frame sum trailer word.
module pcm_frame_packer #(
   parameter int NUM_MICS         = 9,
   parameter int BIT_WIDTH        = 24,
   parameter int FRAME_DEPTH      = 4,
   parameter int FRAME_DEPTH_LOG2 = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [NUM_MICS*BIT_WIDTH-1:0] in_data,
   input  logic                          ssel,
   input  logic                          data_needed,
   output logic [23:0]                   tx_word,
   output logic [FRAME_DEPTH_LOG2:0]     frames_avail,
   output logic [15:0]                   overflow_cnt,
   output logic                          busy
);
   typedef enum logic [1:0] {IDLE, HDR, SAMP, TRL} state_t;
   localparam int IW = $clog2(NUM_MICS + 1);
   localparam int AW = $clog2(FRAME_DEPTH * NUM_MICS);
   localparam logic [23:0] FILL = 24'h000007;
   localparam logic [IW-1:0] LAST = IW'(NUM_MICS - 1);
   localparam logic [FRAME_DEPTH_LOG2:0] FULL = (FRAME_DEPTH_LOG2+1)'(FRAME_DEPTH);
   localparam logic [FRAME_DEPTH_LOG2:0] ONE = (FRAME_DEPTH_LOG2+1)'(1);
   state_t state, state_n;
   logic [IW-1:0] idx, idx_n, sidx;
   logic [23:0] tx_n, samp;
   logic [23:0] mem [FRAME_DEPTH*NUM_MICS];
   logic [FRAME_DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
   logic [7:0] seq;
   logic [1:0] ssel_h, dn_h;
   logic ssel_fall, dn_rise, pop, wr, fin;
   assign ssel_fall = ssel_h[1] & ~ssel_h[0];
   assign dn_rise = ~dn_h[1] & dn_h[0];
   // a pop in the same cycle frees the slot, so a full store can still accept
   assign wr = in_valid & ((frames_avail != FULL) | pop);
   assign busy = state != IDLE;
   assign sidx = (state == SAMP && idx != LAST) ? idx + 1'b1 : '0;
   assign samp = mem[AW'(int'(rd_ptr) * NUM_MICS + int'(sidx))];
   always_ff @(posedge clk)
      if (wr)
         for (int k = 0; k < NUM_MICS; k++)
            mem[AW'(int'(wr_ptr) * NUM_MICS + k)] <= 24'(in_data[k*BIT_WIDTH +: BIT_WIDTH]);
`ifdef PACKER_CHECKSUM_EN
   logic [23:0] csum [FRAME_DEPTH];
   logic [23:0] sum;
   always_comb begin
      sum = '0;
      for (int k = 0; k < NUM_MICS; k++)
         sum = sum + 24'(in_data[k*BIT_WIDTH +: BIT_WIDTH]);
   end
   always_ff @(posedge clk)
      if (wr) csum[wr_ptr] <= sum;
   assign fin = state == TRL;
`else
   assign fin = state == SAMP && idx == LAST;
`endif
   always_comb begin
      state_n = state;
      idx_n = idx;
      tx_n = tx_word;
      pop = 1'b0;
      if (ssel_h[0]) begin
         state_n = IDLE;
         idx_n = '0;
      end else if (ssel_fall) begin
         state_n = (frames_avail != '0) ? HDR : IDLE;
         tx_n = (frames_avail != '0) ? {8'hA5, seq, 8'(frames_avail)} : FILL;
         idx_n = '0;
      end else if (dn_rise && state == HDR) begin
         state_n = SAMP;
         idx_n = '0;
         tx_n = samp;
      end else if (dn_rise && fin) begin
         pop = 1'b1;
         state_n = (frames_avail != ONE) ? HDR : IDLE;
         tx_n = (frames_avail != ONE) ? {8'hA5, seq + 8'd1, 8'(frames_avail)} : FILL;
         idx_n = '0;
      end else if (dn_rise && state == SAMP && idx != LAST) begin
         idx_n = idx + 1'b1;
         tx_n = samp;
`ifdef PACKER_CHECKSUM_EN
      end else if (dn_rise && state == SAMP) begin
         state_n = TRL;
         tx_n = csum[rd_ptr];
`endif
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         idx <= '0;
         tx_word <= FILL;
         rd_ptr <= '0;
         wr_ptr <= '0;
         seq <= '0;
         frames_avail <= '0;
         overflow_cnt <= '0;
         ssel_h <= 2'b11;
         dn_h <= 2'b00;
      end else begin
         state <= state_n;
         idx <= idx_n;
         tx_word <= tx_n;
         rd_ptr <= rd_ptr + FRAME_DEPTH_LOG2'(pop);
         wr_ptr <= wr_ptr + FRAME_DEPTH_LOG2'(wr);
         seq <= seq + 8'(pop);
         frames_avail <= frames_avail + (FRAME_DEPTH_LOG2+1)'(wr) - (FRAME_DEPTH_LOG2+1)'(pop);
         if (in_valid && !wr && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
         ssel_h <= {ssel_h[0], ssel};
         dn_h <= {dn_h[0], data_needed};
      end
endmodule

// File: tb/tb_pcm_frame_packer.sv
// tb_pcm_frame_packer: directed stimulus with a tx_word scoreboard checked by an independent monitor.
module tb_pcm_frame_packer;
   localparam int NM = 9;
   localparam logic [23:0] FILL = 24'h000007;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, ssel = 1'b1, data_needed = 1'b0;
   logic [NM*24-1:0] in_data = '0;
   logic [23:0] tx_word;
   logic [2:0] frames_avail;
   logic [15:0] overflow_cnt;
   logic busy;
   int tests = 0, fails = 0, nword = 0;
   logic [23:0] exp_q[$];
   always #5 clk = ~clk;
   pcm_frame_packer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .ssel(ssel),
      .data_needed(data_needed), .tx_word(tx_word), .frames_avail(frames_avail),
      .overflow_cnt(overflow_cnt), .busy(busy)
   );
   task automatic check(string name, logic [31:0] act, logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, want);
      end
   endtask
   function automatic logic [23:0] hdr(logic [7:0] s, logic [7:0] a);
      return {8'hA5, s, a};
   endfunction
   // every word request (ssel fall or data_needed rise) is answered 1 cycle after the DUT sees it
   initial begin : monitor
      forever begin
         @(posedge data_needed or negedge ssel);
         repeat (3) @(negedge clk);
         nword++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL word%0d: unexpected request, tx_word=%h", nword, tx_word);
         end else check($sformatf("word%0d", nword), tx_word, exp_q.pop_front());
      end
   end
   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_reset;
      rst = 1'b1;
      ssel = 1'b1;
      data_needed = 1'b0;
      in_valid = 1'b0;
      cyc(3);
      rst = 1'b0;
      cyc(1);
   endtask
   task automatic load(logic [23:0] b);
      for (int k = 0; k < NM; k++) in_data[k*24 +: 24] = b + 24'(k);
   endtask
   task automatic frame(logic [23:0] b);
      load(b);
      @(negedge clk);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cyc(1);
   endtask
   task automatic word(logic [23:0] e, bit wfr = 1'b0, logic [23:0] b = '0);
      exp_q.push_back(e);
      @(negedge clk);
      data_needed = 1'b1;
      @(negedge clk);
      if (wfr) begin
         load(b);
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      data_needed = 1'b0;
      cyc(3);
   endtask
   task automatic body(logic [23:0] b);
      for (int k = 0; k < NM; k++) word(b + 24'(k));
`ifdef PACKER_CHECKSUM_EN
      begin
         logic [23:0] s;
         s = '0;
         for (int k = 0; k < NM; k++) s = s + b + 24'(k);
         word(s);
      end
`endif
   endtask
   task automatic start_xfer(logic [23:0] e);
      exp_q.push_back(e);
      @(negedge clk);
      ssel = 1'b0;
      cyc(6);
   endtask
   task automatic end_xfer;
      @(negedge clk);
      ssel = 1'b1;
      cyc(4);
   endtask
   initial begin
      do_reset;
      check("rst_tx", tx_word, FILL);
      check("rst_avail", frames_avail, 0);
      check("rst_ovf", overflow_cnt, 0);
      check("rst_busy", busy, 0);
      start_xfer(FILL);
      check("empty_busy", busy, 0);
      end_xfer;
      frame(24'h1);
      check("one_avail", frames_avail, 1);
      start_xfer(hdr(8'd0, 8'd1));
      check("xfer_busy", busy, 1);
      body(24'h1);
      word(FILL);
      check("pop_avail", frames_avail, 0);
      check("pop_busy", busy, 0);
      word(FILL);
      end_xfer;
      frame(24'h100);
      start_xfer(hdr(8'd1, 8'd1));
      body(24'h100);
      word(FILL);
      end_xfer;
      do_reset;
      for (int b = 1; b <= 5; b++) frame(24'(b * 16));
      check("full_avail", frames_avail, 4);
      check("full_ovf", overflow_cnt, 1);
      start_xfer(hdr(8'd0, 8'd4));
      word(24'h10);
      word(24'h11);
      word(24'h12);
      end_xfer;
      check("abort_busy", busy, 0);
      check("abort_avail", frames_avail, 4);
      start_xfer(hdr(8'd0, 8'd4));
      body(24'h10);
      word(hdr(8'd1, 8'd4), 1'b1, 24'h60);
      check("popwr_avail", frames_avail, 4);
      check("popwr_ovf", overflow_cnt, 1);
      body(24'h20);
      word(hdr(8'd2, 8'd4));
      body(24'h30);
      word(hdr(8'd3, 8'd3));
      body(24'h40);
      word(hdr(8'd4, 8'd2));
      body(24'h60);
      word(FILL);
      check("drain_avail", frames_avail, 0);
      end_xfer;
      check("drain_ovf", overflow_cnt, 1);
      frame(24'h70);
      exp_q.push_back(hdr(8'd5, 8'd1));
      @(negedge clk);
      ssel = 1'b0;
      data_needed = 1'b1;
      cyc(3);
      data_needed = 1'b0;
      cyc(3);
      word(24'h70);
      check("mid_busy", busy, 1);
      rst = 1'b1;
      cyc(2);
      check("midrst_tx", tx_word, FILL);
      check("midrst_avail", frames_avail, 0);
      check("midrst_busy", busy, 0);
      rst = 1'b0;
      ssel = 1'b1;
      cyc(3);
      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
